icache_assoc: RTL and testbench

- Parametrised set-associative instruction cache that replaces the single-word direct-mapped icache between the datapath fetch stage and the memory controller.
- Supports multi-word blocks filled by sequential word requests, 1/2/4 ways with round-robin replacement, and fill abort on fetch redirect.
- Presents the same fetch-side handshake (imemREN/imemaddr -> ihit/imemload) and controller-side handshake (iREN/iaddr <- iwait/iload) as flat ports.

---
 rtl/icache_assoc.sv | 220 ++++++++++++++++++++++
 tb/tb_icache_assoc.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word blocks, round-robin replacement and fill abort.
// Optional macro ICACHE_PERF_CNT_EN builds the hit/miss performance counters.
module icache_assoc #(
    parameter int WAYS        = 2,
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int OFF_W  = $clog2(BLOCK_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam int OFF_SW = (OFF_W > 0) ? OFF_W : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state;
    state_t next_state;

    logic [29:0]       req_word;
    logic [OFF_SW-1:0] req_offset;
    logic [IDX_W-1:0]  req_index;
    logic [TAG_W-1:0]  req_tag;
    logic              unused_addr_bits;

    logic [WAYS-1:0]   line_valid [SETS];
    logic [TAG_W-1:0]  line_tag   [SETS][WAYS];
    logic [31:0]       line_data  [SETS][WAYS][BLOCK_WORDS];

    logic [31:0]       fill_buf [BLOCK_WORDS];
    logic [TAG_W-1:0]  miss_tag;
    logic [IDX_W-1:0]  miss_index;
    logic [OFF_SW-1:0] wc;
    logic [29:0]       fill_word;

    logic              hit_any;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  rr_way;
    logic              victim_found;

    logic              start_miss;
    logic              fill_abort;
    logic              last_word;
    logic              accept;
    logic              commit;

    assign req_word         = imemaddr[31:2];
    assign req_offset       = OFF_SW'(req_word & 30'(BLOCK_WORDS - 1));
    assign req_index        = IDX_W'(req_word >> OFF_W);
    assign req_tag          = TAG_W'(req_word >> (OFF_W + IDX_W));
    assign unused_addr_bits = ^imemaddr[1:0];

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (line_valid[req_index][w] && (line_tag[req_index][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign ihit     = imemREN && (state == IDLE) && hit_any;
    assign imemload = ihit ? line_data[req_index][hit_way][req_offset] : 32'h0;

    // Any change of the requested block or a dropped request cancels the fill.
    assign fill_abort = !imemREN || (req_tag != miss_tag) || (req_index != miss_index);
    assign last_word  = (wc == OFF_SW'(BLOCK_WORDS - 1));
    assign accept     = (state == FILL) && !fill_abort && !iwait;
    assign commit     = accept && last_word;

    assign fill_word = (30'(miss_tag) << (OFF_W + IDX_W))
                     | (30'(miss_index) << OFF_W)
                     | 30'(wc);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_miss = 1'b0;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        case (state)
            IDLE: begin
                if (imemREN && !hit_any) begin
                    next_state = FILL;
                    start_miss = 1'b1;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = {fill_word, 2'b00};
                if (fill_abort || (!iwait && last_word)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    generate
        if (WAYS > 1) begin : g_rr
            logic [WAY_W-1:0] victim_ptr [SETS];

            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int s = 0; s < SETS; s++) begin
                        victim_ptr[s] <= '0;
                    end
                end else if (commit) begin
                    victim_ptr[miss_index] <= victim_ptr[miss_index] + WAY_W'(1);
                end
            end

            assign rr_way = victim_ptr[miss_index];
        end else begin : g_dm
            assign rr_way = '0;
        end
    endgenerate

    // Empty ways are always preferred; the round-robin pointer only decides among full sets.
    always_comb begin
        victim       = rr_way;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !line_valid[miss_index][w]) begin
                victim       = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                line_valid[s] <= '0;
            end
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                fill_buf[w] <= 32'h0;
            end
            wc         <= '0;
            miss_tag   <= '0;
            miss_index <= '0;
        end else begin
            if (start_miss) begin
                miss_tag   <= req_tag;
                miss_index <= req_index;
                wc         <= '0;
            end
            if (accept) begin
                fill_buf[wc] <= iload;
                if (last_word) begin
                    line_valid[miss_index][victim] <= 1'b1;
                end else begin
                    wc <= wc + OFF_SW'(1);
                end
            end
        end
    end

    // The final word bypasses the buffer so the whole line lands in one write.
    always_ff @(posedge CLK) begin
        if (!RST && commit) begin
            line_tag[miss_index][victim] <= miss_tag;
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                line_data[miss_index][victim][w] <= (OFF_SW'(w) == wc) ? iload : fill_buf[w];
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt  <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            if (ihit) begin
                hit_cnt <= hit_cnt + 32'h1;
            end
            if (start_miss) begin
                miss_cnt <= miss_cnt + 32'h1;
            end
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`else
    assign hit_count  = 32'h0;
    assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: directed vector table, corner-case sequences and a
// randomized run compared against a block-level behavioural model of the cache.
module tb_icache_assoc;

    localparam int WAYS = 2;
    localparam int SETS = 8;
    localparam int BW   = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    icache_assoc #(
        .WAYS(WAYS),
        .SETS(SETS),
        .BLOCK_WORDS(BW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .ihit(ihit),
        .imemload(imemload),
        .iREN(iREN),
        .iaddr(iaddr),
        .iwait(iwait),
        .iload(iload),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    // Behavioural model: whole blocks keyed by block number = byte address / (4*BW).
    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS][BW];
    int          m_ptr   [SETS];
    logic [31:0] m_buf   [BW];
    bit          m_filling;
    int unsigned m_block;
    int          m_wc;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    int          mem_age;
    logic [31:0] mem_addr;
    bit          mem_active;
    bit          rand_wait;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hAAAA0001;
        if (a == 32'h44) return 32'hAAAA0002;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic bit model_lookup(input logic [31:0] a, output logic [31:0] word);
        int unsigned blk = a / (4 * BW);
        int unsigned set = blk % SETS;
        int unsigned tag = blk / SETS;
        int unsigned off = (a / 4) % BW;
        word = 32'h0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[set][w] && m_tag[set][w] == tag) begin
                word = m_data[set][w][off];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        m_filling = 1'b0;
        m_wc      = 0;
        m_hits    = 32'h0;
        m_misses  = 32'h0;
    endtask

    task automatic model_commit();
        int unsigned set = m_block % SETS;
        int way = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (way < 0 && !m_valid[set][w]) way = w;
        end
        if (way < 0) way = m_ptr[set];
        m_valid[set][way] = 1'b1;
        m_tag[set][way]   = m_block / SETS;
        for (int i = 0; i < BW; i++) m_data[set][way][i] = m_buf[i];
        m_ptr[set] = (m_ptr[set] + 1) % WAYS;
        m_filling  = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] word;
        bit hit;
        if (RST) begin
            model_reset();
            return;
        end
        hit = model_lookup(imemaddr, word) && imemREN && !m_filling;
`ifdef ICACHE_PERF_CNT_EN
        if (hit) m_hits = m_hits + 32'h1;
`endif
        if (!m_filling) begin
            if (imemREN && !hit) begin
                m_filling = 1'b1;
                m_block   = imemaddr / (4 * BW);
                m_wc      = 0;
`ifdef ICACHE_PERF_CNT_EN
                m_misses = m_misses + 32'h1;
`endif
            end
        end else if (!imemREN || (imemaddr / (4 * BW)) != m_block) begin
            m_filling = 1'b0;
        end else if (!iwait) begin
            m_buf[m_wc] = iload;
            if (m_wc == BW - 1) model_commit();
            else m_wc++;
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] word;
        bit found;
        bit h;
        found = model_lookup(imemaddr, word);
        h = found && imemREN && !m_filling;
        checkValue("ihit", 32'(ihit), 32'(h));
        checkValue("imemload", imemload, h ? word : 32'h0);
        checkValue("iREN", 32'(iREN), 32'(m_filling));
        checkValue("iaddr", iaddr, m_filling ? 32'((m_block * BW + m_wc) * 4) : 32'h0);
        checkValue("hit_count", hit_count, m_hits);
        checkValue("miss_count", miss_count, m_misses);
    endtask

    // Drives one cycle's inputs at the falling edge; RAM answers one cycle after a new request.
    task automatic applyStimulus(input logic rst, input logic ren, input logic [31:0] addr);
        @(negedge CLK);
        RST      = rst;
        imemREN  = ren;
        imemaddr = addr;
        #1;
        if (!iREN) begin
            mem_active = 1'b0;
            mem_age    = 0;
        end else if (!mem_active || iaddr != mem_addr) begin
            mem_active = 1'b1;
            mem_addr   = iaddr;
            mem_age    = 0;
        end
        if (iREN && mem_age >= 1 && (!rand_wait || $urandom_range(0, 2) != 0)) begin
            iwait      = 1'b0;
            iload      = ram_word(iaddr);
            mem_active = 1'b0;
        end else begin
            iwait = 1'b1;
            iload = $urandom;
        end
        mem_age++;
        #1;
        if (!rst) checkOutput();
    endtask

    task automatic advance();
        @(posedge CLK);
        model_step();
    endtask

    task automatic cycle(input logic rst, input logic ren, input logic [31:0] addr);
        applyStimulus(rst, ren, addr);
        advance();
    endtask

    task automatic fetch_until_hit(input logic [31:0] addr);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            applyStimulus(1'b0, 1'b1, addr);
            got = ihit;
            advance();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL fetch timeout: addr 0x%08h got no ihit, expected ihit within 40 cycles", addr);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ren;
        logic [31:0] addr;
        logic        exp_ihit;
        logic [31:0] exp_load;
        logic        exp_iren;
        logic [31:0] exp_iaddr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] cur_addr;
        logic [31:0] exp_hits;
        logic [31:0] exp_misses;

        model_reset();
        mem_age    = 0;
        mem_addr   = 32'h0;
        mem_active = 1'b0;
        rand_wait  = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0,         1'b0, 32'h00};
        vecs[1] = '{1'b0, 1'b1, 32'h40, 1'b0, 32'h0,         1'b0, 32'h00};
        vecs[2] = '{1'b0, 1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h40};
        vecs[3] = '{1'b0, 1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h40};
        vecs[4] = '{1'b0, 1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h44};
        vecs[5] = '{1'b0, 1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h44};
        vecs[6] = '{1'b0, 1'b1, 32'h40, 1'b1, 32'hAAAA0001,  1'b0, 32'h00};
        vecs[7] = '{1'b0, 1'b1, 32'h44, 1'b1, 32'hAAAA0002,  1'b0, 32'h00};

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ren, vecs[i].addr);
            if (!vecs[i].rst) begin
                checkValue($sformatf("vec%0d ihit", i), 32'(ihit), 32'(vecs[i].exp_ihit));
                checkValue($sformatf("vec%0d imemload", i), imemload, vecs[i].exp_load);
                checkValue($sformatf("vec%0d iREN", i), 32'(iREN), 32'(vecs[i].exp_iren));
                checkValue($sformatf("vec%0d iaddr", i), iaddr, vecs[i].exp_iaddr);
            end
            advance();
        end

        // Replacement in set 0: 0x40 (way 0) is evicted by 0xC0.
        fetch_until_hit(32'h80);
        fetch_until_hit(32'hC0);
        applyStimulus(1'b0, 1'b1, 32'h80);
        checkValue("repl 0x80 hit", 32'(ihit), 32'h1);
        advance();
        applyStimulus(1'b0, 1'b1, 32'h40);
        checkValue("repl 0x40 miss", 32'(ihit), 32'h0);
        advance();
        applyStimulus(1'b0, 1'b1, 32'h40);
        checkValue("repl 0x40 iREN", 32'(iREN), 32'h1);
        checkValue("repl 0x40 iaddr", iaddr, 32'h40);
        advance();

        // Abort on dropped request after the first word of 0x100.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h100);
        cycle(1'b0, 1'b0, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h100);
        checkValue("drop iREN", 32'(iREN), 32'h0);
        advance();
        applyStimulus(1'b0, 1'b1, 32'h100);
        checkValue("drop 0x100 miss", 32'(ihit), 32'h0);
        advance();
        applyStimulus(1'b0, 1'b1, 32'h100);
        checkValue("refill iaddr", iaddr, 32'h100);
        advance();
        fetch_until_hit(32'h100);

        // Abort on redirect from 0x200 to 0x300.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h200);
        applyStimulus(1'b0, 1'b1, 32'h300);
        checkValue("redirect abort iREN", 32'(iREN), 32'h1);
        advance();
        applyStimulus(1'b0, 1'b1, 32'h300);
        checkValue("redirect idle iREN", 32'(iREN), 32'h0);
        advance();
        applyStimulus(1'b0, 1'b1, 32'h300);
        checkValue("redirect new iaddr", iaddr, 32'h300);
        advance();
        fetch_until_hit(32'h300);
        applyStimulus(1'b0, 1'b1, 32'h200);
        checkValue("redirect 0x200 miss", 32'(ihit), 32'h0);
        advance();
        cycle(1'b0, 1'b0, 32'h0);

        // Reset while a fill is in flight.
        fetch_until_hit(32'h40);
        cycle(1'b0, 1'b1, 32'h500);
        cycle(1'b0, 1'b1, 32'h500);
        cycle(1'b1, 1'b1, 32'h500);
        applyStimulus(1'b0, 1'b0, 32'h40);
        checkValue("reset iREN", 32'(iREN), 32'h0);
        advance();
        applyStimulus(1'b0, 1'b1, 32'h40);
        checkValue("reset 0x40 miss", 32'(ihit), 32'h0);
        advance();
        cycle(1'b0, 1'b0, 32'h0);

        // Randomized run with variable RAM latency and occasional resets.
        rand_wait = 1'b1;
        cur_addr  = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cur_addr = 32'(((($urandom_range(0, 5) * SETS) + $urandom_range(0, 1)) * BW
                                 + $urandom_range(0, BW - 1)) * 4) | 32'($urandom_range(0, 3));
            end
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, cur_addr);
        end
        rand_wait = 1'b0;

        // Counters: one cold miss followed by three hit cycles.
        cycle(1'b1, 1'b0, 32'h0);
        fetch_until_hit(32'h40);
        cycle(1'b0, 1'b1, 32'h40);
        cycle(1'b0, 1'b1, 32'h44);
`ifdef ICACHE_PERF_CNT_EN
        exp_hits   = 32'd3;
        exp_misses = 32'd1;
`else
        exp_hits   = 32'd0;
        exp_misses = 32'd0;
`endif
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkValue("perf hit_count", hit_count, exp_hits);
        checkValue("perf miss_count", miss_count, exp_misses);
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
